// File: rtl/arb8way16_if.sv
// Bundles arb8way16 request/data inputs and output-word handshake; the arbiter takes the master modport.
// Build-time macro ARB_LOCK_EN adds the per-slot lock input.
interface arb8way16_if #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 16
);
    logic [7:0]         req;
    logic [8*WIDTH-1:0] data_in;
    logic [7:0]         ack;
    logic [7:0]         grant;
    logic [2:0]         sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] xfer_count;
`ifdef ARB_LOCK_EN
    logic [7:0]         lock;

    modport master (
        input  req, data_in, out_ready, lock,
        output ack, grant, sel, out_data, out_valid, xfer_count
    );
    modport slave (
        output req, data_in, out_ready, lock,
        input  ack, grant, sel, out_data, out_valid, xfer_count
    );
`else
    modport master (
        input  req, data_in, out_ready,
        output ack, grant, sel, out_data, out_valid, xfer_count
    );
    modport slave (
        output req, data_in, out_ready,
        input  ack, grant, sel, out_data, out_valid, xfer_count
    );
`endif
endinterface

// File: rtl/arb8way16.sv
// Round-robin 8-way arbiter capturing the winner's word onto one valid/ready output bus.
// Latency: req -> out_valid one cycle; back-to-back grants when another slot waits at accept.
// Backpressure: word, grant and sel hold while out_ready is low. Macro ARB_LOCK_EN adds slot locking.
module arb8way16 #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    arb8way16_if.master    bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [2:0]         r_ptr;
    logic [7:0]         r_grant;
    logic [2:0]         r_sel;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic [COUNT_W-1:0] r_xfer_count;

    state_t             w_state_nxt;
    logic [2:0]         w_ptr_nxt;
    logic [7:0]         w_grant_nxt;
    logic [2:0]         w_sel_nxt;
    logic [WIDTH-1:0]   w_data_nxt;
    logic               w_valid_nxt;
    logic [COUNT_W-1:0] w_count_nxt;

    logic               w_accept;
    logic               w_lock_hit;
    logic [2:0]         w_base;
    logic [7:0]         w_arb_req;
    logic [2:0]         w_idx;
    logic               w_found;
    logic [2:0]         w_win;
    logic [2:0]         w_load_idx;
    logic [WIDTH-1:0]   w_words [8];

    assign w_accept = r_out_valid & bus.out_ready;

`ifdef ARB_LOCK_EN
    assign w_lock_hit = w_accept & bus.lock[r_sel] & bus.req[r_sel];
`else
    assign w_lock_hit = 1'b0;
`endif

    // While busy, the next search starts just past the slot being served and skips it.
    assign w_base    = (r_state == BUSY) ? (r_sel + 3'd1) : r_ptr;
    assign w_arb_req = bus.req & ~((r_state == BUSY) ? r_grant : 8'h00);

    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 3'd0;
        // Descending scan so the slot nearest the base is written last and wins.
        for (int k = 7; k >= 0; k--) begin
            w_idx = w_base + 3'(k);
            if (w_arb_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_words[k] = bus.data_in[k*WIDTH +: WIDTH];
        end
    end

    assign w_load_idx = w_lock_hit ? r_sel : w_win;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_data_nxt  = r_out_data;
        w_valid_nxt = r_out_valid;
        w_count_nxt = r_xfer_count;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = 8'h01 << w_win;
                    w_sel_nxt   = w_win;
                    w_data_nxt  = w_words[w_win];
                    w_valid_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (w_accept) begin
                    w_count_nxt = r_xfer_count + COUNT_W'(1);
                    if (!w_lock_hit) begin
                        w_ptr_nxt = r_sel + 3'd1;
                    end
                    if (w_lock_hit || w_found) begin
                        w_grant_nxt = 8'h01 << w_load_idx;
                        w_sel_nxt   = w_load_idx;
                        w_data_nxt  = w_words[w_load_idx];
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = 8'h00;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= 3'd0;
            r_grant      <= 8'h00;
            r_sel        <= 3'd0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_grant      <= w_grant_nxt;
            r_sel        <= w_sel_nxt;
            r_out_data   <= w_data_nxt;
            r_out_valid  <= w_valid_nxt;
            r_xfer_count <= w_count_nxt;
        end
    end

    // A word caught by reset is dropped, so no ack may escape in that cycle.
    assign bus.ack        = (w_accept && !rst) ? r_grant : 8'h00;
    assign bus.grant      = r_grant;
    assign bus.sel        = r_sel;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.xfer_count = r_xfer_count;

endmodule

// File: doc/arb8way16.md
Name: arb8way16

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit output bus among 8 requesters.
- Selects a winner, captures that requester's word, and presents it downstream with a valid/ready handshake.
- Exports the winning index as a 3-bit select in the same encoding as the 8-way 16-bit mux: 3'b000 = slot a … 3'b111 = slot h.

Parameters:
- WIDTH, 16, data width per requester and of the output word.
- COUNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request per slot; bit i = slot i.
- data_in  input  8*WIDTH  packed slot words; slot i at [WIDTH*i+WIDTH-1 : WIDTH*i].
- ack  output  8  one-hot pulse; the slot's word was accepted downstream this cycle.
- grant  output  8  one-hot; the slot currently owning the output (registered).
- sel  output  3  binary index of the granted slot (registered).
- out_data  output  WIDTH  captured word (registered).
- out_valid  output  1  out_data holds an unaccepted word.
- out_ready  input  1  downstream accepts when high with out_valid.
- xfer_count  output  COUNT_W  number of completed transfers.

Behaviour:
- Reset values (sync rst high at an edge): out_valid=0, grant=0, sel=0, out_data=0, xfer_count=0, round-robin pointer ptr=0, state=IDLE.
- Reset mid-transfer discards the pending word; no ack is issued for it.
- The state machine has two states: IDLE and BUSY.
- Arbitration search: scan slots ptr, ptr+1, …, ptr+7, mod 8 wrap; the first slot with req=1 wins.
- IDLE:
  - If any req bit is high at edge N, arbitrate.
  - At edge N: grant=onehot(winner), sel=winner, out_data=data_in slot winner sampled at edge N, out_valid=1, state=BUSY.
  - Latency req -> out_valid is 1 cycle.
  - If req=0, stay in IDLE with all outputs held.
- BUSY:
  - out_data, sel and grant stay stable while out_valid=1 and out_ready=0.
  - Accept cycle (out_valid & out_ready): ack = grant combinationally, for that cycle only.
  - At the accept edge: xfer_count increments (wraps 2^COUNT_W-1 -> 0) and ptr = sel+1 mod 8 (7 -> 0).
  - In the same accept cycle, rearbitrate over req with the just-served slot masked. If any slot wins, load it as in IDLE: back-to-back, out_valid stays 1. Otherwise out_valid=0, grant=0, state=IDLE, and sel keeps its last value.
  - A sole continuous requester therefore gets one transfer every 2 cycles.
- Requester rules:
  - A requester holds req until it sees its ack.
  - Data is sampled only at its grant edge, so later data_in changes do not affect out_data.
  - Dropping req while granted does not revoke the grant; the captured word is still delivered.
- ack is never asserted when out_valid=0.
- ack and grant are always 0 or one-hot.

Optional Feature:
- Macro: ARB_LOCK_EN
- Defined:
  - Adds input port lock (8 bits).
  - If lock[sel]=1 and req[sel]=1 in the accept cycle, the same slot is re-granted immediately. data_in of that slot is captured at the accept edge, out_valid stays 1, and ptr is not advanced.
  - Other slots are starved while lock is held.
  - The lock bit of a non-granted slot has no effect.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> out_valid=0, grant=0, sel=0, xfer_count=0. First edge after release -> grant=8'h01, sel=3'b000, out_data=slot0 word.
- Rotation: req=8'hFF, slot i word = 16'h1111*i, out_ready=1 constant -> sel sequence 0,1,…,7,0, back-to-back out_valid=1, out_data 16'h0000,16'h1111,…,16'h7777, xfer_count=8 after 8 accepts.
- Backpressure: req=8'h04, out_ready=0 for 5 cycles with data_in slot2 changed after the grant -> out_valid held, out_data = value at grant edge, ack=0. Raise out_ready -> single ack=8'h04 pulse.
- Sole requester: req=8'h80 held, out_ready=1 -> accept every other cycle, out_valid pattern 1,0,1,0, sel stays 3'b111.
- Wrap/pointer: serve slot 7, then req=8'h81 -> next winner slot 0; after that, slot 7 wins.
- ARB_LOCK_EN: req=8'h03, lock=8'h01, out_ready=1 -> slot 0 served 4 consecutive cycles, slot 1 not served. Drop lock -> slot 1 granted on the next accept.
